// File: rtl/voxel_gpu_csr_pkg.sv
// Shared types and CSR map for the voxel GPU host-register front end.
// The optional build macro VOXEL_GPU_PERF_CNT_EN enables LAST_RENDER_CYCLES at CSR_PERF.
package gpu;
    typedef struct packed {
        logic [31:0] x, y, z;
    } vec3_t;

    // Word order on the bus: pos, look0..look3, each x,y,z.
    typedef struct packed {
        vec3_t pos, look0, look1, look2, look3;
    } camera;

    localparam int CAM_WORDS     = 15;
    localparam int CSR_PIXEL_BUF = 'h00;
    localparam int CSR_VOXEL_BUF = 'h01;
    localparam int CSR_VOXEL_CNT = 'h02;
    localparam int CSR_PAL_BUF   = 'h03;
    localparam int CSR_PAL_LEN   = 'h04;
    localparam int CSR_PERF      = 'h0D;
    localparam int CSR_STATUS    = 'h0E;
    localparam int CSR_CTRL      = 'h0F;
    localparam int CSR_CAM_BASE  = 'h10;

    typedef struct packed {
        logic [15:0] frame_count;
        logic [12:0] rsvd;
        logic        start_err;
        logic        irq_pending;
        logic        busy;
    } status_t;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} render_state_t;
endpackage

// File: rtl/voxel_gpu_csr_if.sv
// Avalon-MM slave bus bundle between the HPS bridge and the voxel GPU CSR block.
interface voxel_gpu_csr_if #(parameter int ADDR_BITS = 8);
    logic [ADDR_BITS-1:0] address;
    logic                 read;
    logic                 write;
    logic [31:0]          writedata;
    logic [31:0]          readdata;
    logic                 waitrequest;

    modport master (output address, read, write, writedata, input readdata, waitrequest);
    modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/voxel_gpu_csr_render_seq.sv
// Render sequencer: launch pulse, per-core done aggregation, frame counter.
// VOXEL_GPU_PERF_CNT_EN adds a saturating RUN-cycle counter latched on completion.
module gpu_render_seq
    import gpu::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int FRAME_CNT_BITS = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic                      busy,
    output logic                      do_render,
    output logic                      latch_cam,
    output logic                      complete,
    output logic [FRAME_CNT_BITS-1:0] frame_count,
    output logic [31:0]               last_cycles
);
    render_state_t        state;
    logic [NUM_CORES-1:0] done_mask, mask_next;

    // The current cycle's pulses count toward completion, so finish on the same edge.
    assign mask_next = done_mask | core_done;
    assign busy      = (state != IDLE);
    assign do_render = (state == LAUNCH);
    assign latch_cam = do_render;
    assign complete  = (state == RUN) && (&mask_next);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            done_mask   <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE:   if (start) state <= LAUNCH;
                LAUNCH: begin
                    done_mask <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    done_mask <= mask_next;
                    if (complete) begin
                        state       <= IDLE;
                        frame_count <= frame_count + FRAME_CNT_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VOXEL_GPU_PERF_CNT_EN
    logic [31:0] run_cycles, run_next;

    assign run_next = (&run_cycles) ? run_cycles : run_cycles + 32'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_cycles  <= '0;
            last_cycles <= '0;
        end else begin
            if (state == LAUNCH)   run_cycles <= '0;
            else if (state == RUN) run_cycles <= run_next;
            if (complete) last_cycles <= run_next;
        end
    end
`else
    assign last_cycles = '0;
`endif
endmodule

// File: rtl/voxel_gpu_csr.sv
// Host register front end for the voxel GPU: config regs, double-buffered camera, IRQ.
// VOXEL_GPU_PERF_CNT_EN makes 0x0D return the last render's cycle count (else 0).
module voxel_gpu_csr
    import gpu::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_BITS      = 8,
    parameter int FRAME_CNT_BITS = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    voxel_gpu_csr_if.slave       s1,
    output logic                 irq,
    output logic [31:0]          pixel_buffer,
    output logic [31:0]          voxel_buffer,
    output logic [31:0]          voxel_count,
    output logic [31:0]          palette_buffer,
    output logic [31:0]          palette_length,
    output camera                cam_active,
    output logic                 do_render,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 busy
);
    logic [4:0][31:0]           cfg;
    logic [CAM_WORDS-1:0][31:0] cam_stage;
    logic irq_pending, start_err, rd_phase;
    logic latch_cam, complete, cfg_hit, cam_hit, start_wr, clear_wr;
    logic [2:0] cfg_idx;
    logic [3:0] cam_idx;
    logic [FRAME_CNT_BITS-1:0] frame_count;
    logic [31:0] last_cycles, rd_mux;
    status_t status;
    int a;

    assign a        = int'(s1.address);
    assign cfg_hit  = (a <= CSR_PAL_LEN);
    assign cam_hit  = (a >= CSR_CAM_BASE) && (a < CSR_CAM_BASE + CAM_WORDS);
    assign cfg_idx  = 3'(a);
    // Bus word 0 (pos.x) is the most significant word of the packed camera.
    assign cam_idx  = 4'(CAM_WORDS - 1 - (a - CSR_CAM_BASE));
    assign start_wr = s1.write && (a == CSR_CTRL) && (s1.writedata != 32'd0);
    assign clear_wr = s1.write && (a == CSR_CTRL) && (s1.writedata == 32'd0);

    assign s1.waitrequest = reset_n && s1.read && !rd_phase;
    assign irq            = irq_pending;
    assign pixel_buffer   = cfg[CSR_PIXEL_BUF];
    assign voxel_buffer   = cfg[CSR_VOXEL_BUF];
    assign voxel_count    = cfg[CSR_VOXEL_CNT];
    assign palette_buffer = cfg[CSR_PAL_BUF];
    assign palette_length = cfg[CSR_PAL_LEN];

    gpu_render_seq #(
        .NUM_CORES      (NUM_CORES),
        .FRAME_CNT_BITS (FRAME_CNT_BITS)
    ) u_seq (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_wr),
        .core_done   (core_done),
        .busy        (busy),
        .do_render   (do_render),
        .latch_cam   (latch_cam),
        .complete    (complete),
        .frame_count (frame_count),
        .last_cycles (last_cycles)
    );

    always_comb begin
        status             = '0;
        status.busy        = busy;
        status.irq_pending = irq_pending;
        status.start_err   = start_err;
        status.frame_count = 16'(frame_count);
    end

    always_comb begin
        rd_mux = '0;
        if (cfg_hit)               rd_mux = cfg[cfg_idx];
        else if (cam_hit)          rd_mux = cam_stage[cam_idx];
        else if (a == CSR_STATUS)  rd_mux = status;
        else if (a == CSR_PERF)    rd_mux = last_cycles;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg         <= '0;
            cam_stage   <= '0;
            cam_active  <= '0;
            irq_pending <= 1'b0;
            start_err   <= 1'b0;
            rd_phase    <= 1'b0;
            s1.readdata <= '0;
        end else begin
            if (s1.write && cfg_hit) cfg[cfg_idx]       <= s1.writedata;
            if (s1.write && cam_hit) cam_stage[cam_idx] <= s1.writedata;
            if (latch_cam) cam_active <= camera'(cam_stage);
            // Completion beats a same-cycle clear so no frame's IRQ is lost.
            if (complete)      irq_pending <= 1'b1;
            else if (clear_wr) irq_pending <= 1'b0;
            if (start_wr && busy) start_err <= 1'b1;
            else if (clear_wr)    start_err <= 1'b0;
            rd_phase <= s1.read && !rd_phase;
            if (s1.read && !rd_phase) s1.readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_voxel_gpu_csr.sv
// Directed bench for voxel_gpu_csr: transaction-level model checked every cycle,
// plus hand-computed literal expectations at key points of the test plan.
module tb_voxel_gpu_csr;
    import gpu::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       irq, do_render, busy;
    logic [31:0] pixel_buffer, voxel_buffer, voxel_count, palette_buffer, palette_length;
    camera      cam_active;
    logic [3:0] core_done = '0;
    int tests = 0;
    int fails = 0;

    voxel_gpu_csr_if #(.ADDR_BITS(8)) bus ();

    voxel_gpu_csr #(.NUM_CORES(4), .ADDR_BITS(8), .FRAME_CNT_BITS(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .s1             (bus.slave),
        .irq            (irq),
        .pixel_buffer   (pixel_buffer),
        .voxel_buffer   (voxel_buffer),
        .voxel_count    (voxel_count),
        .palette_buffer (palette_buffer),
        .palette_length (palette_length),
        .cam_active     (cam_active),
        .do_render      (do_render),
        .core_done      (core_done),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [31:0] m_cfg [5];
    logic [31:0] m_stage [15];
    logic [31:0] m_act [15];
    logic        m_launch, m_running, m_irq, m_err, m_rphase;
    logic [3:0]  m_got;
    logic [15:0] m_frames;
    logic [31:0] m_cycles, m_last, m_rdata;
    logic        m_was_busy, m_done_now;

    function automatic logic [31:0] m_read(input logic [7:0] ad);
        if (ad <= 8'h04) return m_cfg[ad];
        if (ad >= 8'h10 && ad <= 8'h1E) return m_stage[ad - 8'h10];
        if (ad == 8'h0E) return {m_frames, 13'd0, m_err, m_irq, m_launch || m_running};
`ifdef VOXEL_GPU_PERF_CNT_EN
        if (ad == 8'h0D) return m_last;
`endif
        return 32'd0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) m_cfg[i] = '0;
            for (int i = 0; i < 15; i++) begin m_stage[i] = '0; m_act[i] = '0; end
            m_launch = 0; m_running = 0; m_irq = 0; m_err = 0; m_rphase = 0;
            m_got = '0; m_frames = '0; m_cycles = '0; m_last = '0; m_rdata = '0;
        end else begin
            m_was_busy = m_launch || m_running;
            m_done_now = m_running && ((m_got | core_done) == 4'hF);
            if (bus.read && !m_rphase) m_rdata = m_read(bus.address);
            m_rphase = bus.read && !m_rphase;
            if (m_launch) begin
                for (int i = 0; i < 15; i++) m_act[i] = m_stage[i];
                m_got = '0; m_cycles = '0; m_launch = 0; m_running = 1;
            end else if (m_running) begin
                m_got = m_got | core_done;
                if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
                if (m_done_now) begin
                    m_running = 0; m_frames = m_frames + 1; m_last = m_cycles; m_irq = 1;
                end
            end
            if (bus.write) begin
                if (bus.address <= 8'h04) m_cfg[bus.address] = bus.writedata;
                else if (bus.address >= 8'h10 && bus.address <= 8'h1E)
                    m_stage[bus.address - 8'h10] = bus.writedata;
                else if (bus.address == 8'h0F) begin
                    if (bus.writedata != 0) begin
                        if (m_was_busy) m_err = 1; else m_launch = 1;
                    end else begin
                        if (!m_done_now) m_irq = 0;
                        m_err = 0;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cw(input camera c, input int i);
        case (i)
            0: return c.pos.x;    1: return c.pos.y;    2: return c.pos.z;
            3: return c.look0.x;  4: return c.look0.y;  5: return c.look0.z;
            6: return c.look1.x;  7: return c.look1.y;  8: return c.look1.z;
            9: return c.look2.x; 10: return c.look2.y; 11: return c.look2.z;
           12: return c.look3.x; 13: return c.look3.y; default: return c.look3.z;
        endcase
    endfunction

    int bad;
    always @(negedge clock) begin
        if (reset_n) begin
            chk("do_render", 32'(do_render), 32'(m_launch));
            chk("busy", 32'(busy), 32'(m_launch || m_running));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("waitrequest", 32'(bus.waitrequest), 32'(bus.read && !m_rphase));
            if (bus.read && m_rphase) chk("readdata", bus.readdata, m_rdata);
            chk("pixel_buffer", pixel_buffer, m_cfg[0]);
            chk("voxel_buffer", voxel_buffer, m_cfg[1]);
            chk("voxel_count", voxel_count, m_cfg[2]);
            chk("palette_buffer", palette_buffer, m_cfg[3]);
            chk("palette_length", palette_length, m_cfg[4]);
            bad = -1;
            for (int i = 0; i < 15; i++) if (cw(cam_active, i) !== m_act[i]) bad = i;
            tests++;
            if (bad >= 0) begin
                fails++;
                $display("FAIL cam_active word %0d: got %h expected %h", bad, cw(cam_active, bad), m_act[bad]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic w, input logic [7:0] ad, input logic [31:0] d, input logic [3:0] dn);
        bus.write = w; bus.address = ad; bus.writedata = d; core_done = dn;
        step();
        bus.write = 0; core_done = '0;
    endtask

    task automatic wr(input logic [7:0] ad, input logic [31:0] d);
        cyc(1'b1, ad, d, 4'h0);
    endtask

    task automatic rd(input logic [7:0] ad, output logic [31:0] d);
        bus.address = ad; bus.read = 1;
        #1 chk("rd_wait_first", 32'(bus.waitrequest), 32'd1);
        step();
        chk("rd_wait_second", 32'(bus.waitrequest), 32'd0);
        step();
        bus.read = 0;
        d = bus.readdata;
    endtask

    logic [31:0] rv;

    initial begin
        bus.address = '0; bus.read = 0; bus.write = 0; bus.writedata = '0;
        #12;
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_do_render", 32'(do_render), 32'd0);
        chk("reset_readdata", bus.readdata, 32'd0);
        chk("reset_wait", 32'(bus.waitrequest), 32'd0);
        #10 reset_n = 1;
        step();

        rd(8'h0E, rv); chk("status_after_reset", rv, 32'h0);
        chk("irq_after_reset_read", 32'(irq), 32'd0);

        for (int i = 0; i < 5; i++) wr(8'(i), 32'h1000_0000 + 32'(i * 16));
        rd(8'h02, rv); chk("cfg_voxel_count", rv, 32'h1000_0020);
        wr(8'h08, 32'hDEAD_BEEF);
        rd(8'h08, rv); chk("unmapped_read", rv, 32'h0);
        rd(8'h0F, rv); chk("ctrl_write_only", rv, 32'h0);

        wr(8'h10, 32'h0001_0000);
        wr(8'h1E, 32'h0000_ABCD);
        wr(8'h0F, 32'd1);
        chk("launch_do_render", 32'(do_render), 32'd1);
        chk("launch_busy", 32'(busy), 32'd1);
        step();
        chk("do_render_one_cycle", 32'(do_render), 32'd0);
        chk("cam_pos_x_latched", cam_active.pos.x, 32'h0001_0000);
        chk("cam_look3_z_latched", cam_active.look3.z, 32'h0000_ABCD);

        wr(8'h10, 32'h5);
        wr(8'h01, 32'h0000_1234);
        chk("cam_shadow_holds", cam_active.pos.x, 32'h0001_0000);
        rd(8'h10, rv); chk("staging_readback", rv, 32'h5);

        wr(8'h0F, 32'd1);
        chk("no_second_launch", 32'(do_render), 32'd0);
        rd(8'h0E, rv); chk("status_start_err", rv, 32'h0000_0005);

        cyc(1'b0, 8'h0, 32'h0, 4'b0001);
        step();
        cyc(1'b0, 8'h0, 32'h0, 4'b0010);
        cyc(1'b0, 8'h0, 32'h0, 4'b0100);
        chk("still_busy", 32'(busy), 32'd1);
        cyc(1'b0, 8'h0, 32'h0, 4'b1000);
        chk("done_irq", 32'(irq), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        rd(8'h0E, rv); chk("status_frame1", rv, 32'h0001_0006);

        wr(8'h0F, 32'd0);
        chk("cleared_irq", 32'(irq), 32'd0);
        rd(8'h0E, rv); chk("status_cleared", rv, 32'h0001_0000);

        // Pulse during LAUNCH must not count; final pulse races a clear.
        cyc(1'b1, 8'h0F, 32'h80, 4'h0);
        cyc(1'b0, 8'h0, 32'h0, 4'b0001);
        cyc(1'b0, 8'h0, 32'h0, 4'b0110);
        chk("launch_pulse_ignored", 32'(busy), 32'd1);
        cyc(1'b0, 8'h0, 32'h0, 4'b1000);
        chk("core0_outstanding", 32'(busy), 32'd1);
        cyc(1'b1, 8'h0F, 32'h0, 4'b0001);
        chk("complete_beats_clear", 32'(irq), 32'd1);
        rd(8'h0E, rv); chk("status_frame2", rv, 32'h0002_0002);

        // Start with irq pending, then reset mid-RUN.
        wr(8'h0F, 32'd1);
        chk("start_with_irq", 32'(do_render), 32'd1);
        cyc(1'b0, 8'h0, 32'h0, 4'b0001);
        cyc(1'b0, 8'h0, 32'h0, 4'b0010);
        #3 reset_n = 0;
        #1;
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_do_render", 32'(do_render), 32'd0);
        chk("arst_cam", cam_active.pos.x, 32'd0);
        chk("arst_cfg", voxel_buffer, 32'd0);
        chk("arst_readdata", bus.readdata, 32'd0);
        #8 reset_n = 1;
        step();
        cyc(1'b0, 8'h0, 32'h0, 4'b1100);
        cyc(1'b0, 8'h0, 32'h0, 4'b1111);
        chk("post_rst_irq", 32'(irq), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        rd(8'h0E, rv); chk("post_rst_status", rv, 32'h0);

        // 100 RUN cycles for the perf counter.
        wr(8'h0F, 32'd1);
        step();
        repeat (99) step();
        cyc(1'b0, 8'h0, 32'h0, 4'hF);
        rd(8'h0E, rv); chk("status_perf_frame", rv, 32'h0001_0002);
        rd(8'h0D, rv);
`ifdef VOXEL_GPU_PERF_CNT_EN
        chk("perf_cycles", rv, 32'd100);
`else
        chk("perf_absent", rv, 32'd0);
`endif
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
